data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Byte-serial data memory responder for the femtoRV32 core. It consumes the MemRead/MemWrite strobes that the control unit decodes from load/store opcodes, together with the ALU address, funct3 and rs2 data. It performs the access one byte per cycle on an internal byte-wide array, stalling the core until the access completes. It returns sign- or zero-extended load data and flags illegal requests.

## Interface
Parameters:
- ADDR_WIDTH, 12: byte-address bits used; array holds 2^ADDR_WIDTH bytes.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead  in  1  load request from the control unit.
- MemWrite  in  1  store request from the control unit.
- Funct3  in  3  instruction[14:12]; size and signedness.
- Addr  in  32  byte address from the ALU.
- WriteData  in  32  store data (rs2).
- ReadData  out  32  load result, registered, held until the next completed load.
- Stall  out  1  core must hold its PC and instruction.
- Done  out  1  one-cycle pulse; the access completes this cycle.
- Error  out  1  illegal request this cycle; no access performed.

## Operation
- Request: req = MemRead | MemWrite, sampled only in IDLE.
- Size N from Funct3[1:0]: 00→1 byte, 01→2 bytes, 10→4 bytes. 11 is illegal.
- Loads: Funct3[2]=1 selects zero-extend (LBU, LHU). 110 and 111 are illegal.
- Stores: Funct3[2] must be 0.
- Alignment: halfword needs Addr[0]=0; word needs Addr[1:0]=0. Misaligned is illegal.
- MemRead and MemWrite both high is illegal.
- Addr bits above ADDR_WIDTH-1 are ignored, so addresses alias.
- Little-endian: byte k of the access lives at Addr+k and maps to data bits [8k+7:8k].
- FSM states and transitions:
  - IDLE: a legal req latches Addr, WriteData, Funct3 and the direction, clears byte counter k, and moves to ACCESS. An illegal req keeps IDLE, drives Error=1, performs no write and leaves ReadData unchanged.
  - ACCESS: each cycle transfers byte k. A store writes the latched WriteData byte k to array[addr+k]. A load captures array[addr+k] into byte k of a shadow register. k increments; after byte N-1, move to DONE.
  - DONE: Done=1. A load sets ReadData to the shadow value extended from 8N bits: sign-extended when Funct3[2]=0, zero-extended otherwise. A store leaves ReadData unchanged. Always returns to IDLE; req is ignored in this state.
- Array contents are not cleared by reset and are undefined at power-up.

## Timing
- Stall = (IDLE & req & legal) | ACCESS. It is combinational, so it rises in the same cycle the request appears. Stall=0 in DONE so the core advances at the end of the DONE cycle.
- Error = IDLE & req & ~legal, combinational; Stall=0 in that cycle.
- Latency: request accepted in cycle t, bytes transferred in t+1..t+N, Done in t+N+1. Stall is high for t..t+N.
- A new request is accepted earliest in cycle t+N+2. This gives back-to-back accesses with no extra gap beyond DONE.
- Reset (rst_n low, at any time): state goes to IDLE immediately and k=0. ReadData=0, Done=0. Stall and Error are forced to 0 while rst_n is low.
- Reset mid-ACCESS: store bytes already written remain in the array, remaining bytes are not written, and Done never pulses.
- Inputs may change freely during ACCESS; only the values latched in IDLE are used.

## Test plan
- Word store then load: SW 0xDEADBEEF at 0x10 accepted at t gives Stall high t..t+4 and Done at t+5. A following LW 0x10 gives Done at t'+5 and ReadData=0xDEADBEEF.
- Extension (memory as above):
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD.
  - Byte loads Done at t+2; halfword loads Done at t+3.
- Partial store: SB 0x55 at 0x11 (WriteData=0xAAAAAA55), then LW 0x10 → 0xDEAD55EF. SH 0x1234 at 0x12, then LW 0x10 → 0x123455EF.
- Illegal requests each give Error=1 in the same cycle, with Stall=0, no Done, and no ReadData or array change:
  - LW at 0x12.
  - LH at 0x11.
  - MemRead and MemWrite both high.
  - Funct3=011.
  - Store with Funct3=100.
- Reset mid-store: SW 0x11223344 at 0x20 over prior 0xFFFFFFFF, with rst_n pulsed low after two ACCESS cycles. Stall drops at once and Done never pulses. After reset, LW 0x20 → 0xFFFF3344.
- Hold and alias: MemRead kept high through DONE is not re-accepted in that cycle, and a new access starts in the following IDLE. SW 0xCAFEF00D at 0x1010, then LW 0x010 → 0xCAFEF00D (ADDR_WIDTH=12).

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-serial data memory responder: performs loads/stores one byte per cycle
// on a local byte array, stalling the core and returning extended load data.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Error
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            k;
  logic [ADDR_WIDTH-1:0] addr_q, byte_addr;
  logic [31:0]           wdata_q, shadow, merged, ext;
  logic [2:0]            f3_q;
  logic                  store_q;
  logic                  req, legal, align_ok, dir_ok, last;
  logic [1:0]            last_k;
  logic [7:0]            rd_byte;
  logic [7:0]            mem [2**ADDR_WIDTH];

  // upper address bits alias onto the array
  logic unused_addr;
  assign unused_addr = ^Addr[31:ADDR_WIDTH];

  assign req = MemRead | MemWrite;

  always_comb begin
    align_ok = 1'b1;
    if (Funct3[1:0] == 2'b01) align_ok = ~Addr[0];
    if (Funct3[1:0] == 2'b10) align_ok = (Addr[1:0] == 2'b00);
    dir_ok   = MemWrite ? ~Funct3[2] : (Funct3 != 3'b110);
    legal    = ~(MemRead & MemWrite) & (Funct3[1:0] != 2'b11) & dir_ok & align_ok;
  end

  assign last_k    = (f3_q[1:0] == 2'b10) ? 2'd3 : {1'b0, f3_q[0]};
  assign last      = (k == last_k);
  assign byte_addr = addr_q + ADDR_WIDTH'(k);
  assign rd_byte   = mem[byte_addr];

  // shadow with the byte arriving this cycle folded in, so the final value
  // can be registered on the same edge that enters DONE
  always_comb begin
    merged = shadow;
    merged[{k, 3'b000} +: 8] = rd_byte;
    case (f3_q[1:0])
      2'b00:   ext = {{24{~f3_q[2] & merged[7]}},  merged[7:0]};
      2'b01:   ext = {{16{~f3_q[2] & merged[15]}}, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    Error     = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (legal) begin
          state_nxt = ACCESS;
          Stall     = 1'b1;
        end else begin
          Error = 1'b1;
        end
      end
      ACCESS: begin
        Stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      Stall = 1'b0;
      Error = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      store_q  <= 1'b0;
      shadow   <= '0;
      ReadData <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req && legal) begin
          addr_q  <= Addr[ADDR_WIDTH-1:0];
          wdata_q <= WriteData;
          f3_q    <= Funct3;
          store_q <= MemWrite;
          k       <= '0;
        end
        ACCESS: begin
          k <= k + 2'd1;
          if (!store_q) begin
            shadow[{k, 3'b000} +: 8] <= rd_byte;
            if (last) ReadData <= ext;
          end
        end
        default: ;
      endcase
    end
  end

  // array is never reset; reset forces IDLE so an interrupted store stops here
  always_ff @(posedge clk) begin
    if (state == ACCESS && store_q) mem[byte_addr] <= wdata_q[{k, 3'b000} +: 8];
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a byte-array model predicts per-cycle
// Stall/Done/Error/ReadData, and a single compare process checks every cycle.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  Funct3 = '0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, Done, Error;

  int checks = 0;
  int failures = 0;

  logic        e_stall = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_rdata = '0;
  logic [7:0]  mm [4096];

  data_mem_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .Done(Done), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("stall", {31'd0, Stall}, {31'd0, e_stall});
    chk("done",  {31'd0, Done},  {31'd0, e_done});
    chk("error", {31'd0, Error}, {31'd0, e_err});
    chk("rdata", ReadData, e_rdata);
  end

  function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    if (rd && f3 == 3'b110) return 1'b0;
    if (f3[1:0] == 2'b01 && a[0]) return 1'b0;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
  endtask

  task automatic expect_out(input bit st, input bit dn, input bit er);
    e_stall = st; e_done = dn; e_err = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 3'b000, 32'd0, 32'd0);
      expect_out(0, 0, 0);
      tick();
    end
  endtask

  // One request from IDLE through DONE. abort_at >= 0 pulses reset at that ACCESS cycle.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input int abort_at,
                        input bit use_lit, input logic [31:0] lit);
    int n;
    bit ok;
    logic [63:0] v;
    ok = m_legal(rd, wr, f3, a);
    n  = 1 << f3[1:0];
    drive(rd, wr, f3, a, wd);
    expect_out(ok, 0, !ok);
    tick();
    if (!ok) begin
      idle(1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        drive(0, 0, 3'b000, 32'd0, 32'd0);
        expect_out(0, 0, 0);
        e_rdata = '0;
        if (wr) for (int j = 0; j < i; j++) mm[(a + j) & 32'hFFF] = wd[8*j +: 8];
        tick();
        rst_n = 1'b1;
        return;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, $urandom);
      expect_out(1, 0, 0);
      tick();
    end
    if (wr) for (int j = 0; j < n; j++) mm[(a + j) & 32'hFFF] = wd[8*j +: 8];
    if (rd) begin
      v = '0;
      for (int j = 0; j < n; j++) v[8*j +: 8] = mm[(a + j) & 32'hFFF];
      if (!f3[2] && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e_rdata = v[31:0];
    end
    if (hold) drive(rd, wr, f3, a, wd);
    else      drive(0, 0, 3'b000, 32'd0, 32'd0);
    expect_out(0, 1, 0);
    if (use_lit) chk("literal", ReadData, lit);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    idle(2);

    // word store/load and extension
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, -1, 0, 32'h0);
    access(1, 0, 3'b010, 32'h10, 32'h0, 0, -1, 1, 32'hDEADBEEF);
    access(1, 0, 3'b000, 32'h13, 32'h0, 0, -1, 1, 32'hFFFFFFDE);
    access(1, 0, 3'b100, 32'h13, 32'h0, 0, -1, 1, 32'h000000DE);
    access(1, 0, 3'b001, 32'h12, 32'h0, 0, -1, 1, 32'hFFFFDEAD);
    access(1, 0, 3'b101, 32'h12, 32'h0, 0, -1, 1, 32'h0000DEAD);
    idle(1);

    // partial stores
    access(0, 1, 3'b000, 32'h11, 32'hAAAAAA55, 0, -1, 0, 32'h0);
    access(1, 0, 3'b010, 32'h10, 32'h0, 0, -1, 1, 32'hDEAD55EF);
    access(0, 1, 3'b001, 32'h12, 32'h99991234, 0, -1, 0, 32'h0);
    access(1, 0, 3'b010, 32'h10, 32'h0, 0, -1, 1, 32'h123455EF);

    // illegal requests leave array and ReadData alone
    access(1, 0, 3'b010, 32'h12, 32'h0, 0, -1, 0, 32'h0);
    access(1, 0, 3'b001, 32'h11, 32'h0, 0, -1, 0, 32'h0);
    access(1, 1, 3'b010, 32'h10, 32'h0BADF00D, 0, -1, 0, 32'h0);
    access(1, 0, 3'b011, 32'h10, 32'h0, 0, -1, 0, 32'h0);
    access(0, 1, 3'b100, 32'h10, 32'h0BADF00D, 0, -1, 0, 32'h0);
    access(1, 0, 3'b110, 32'h10, 32'h0, 0, -1, 0, 32'h0);
    chk("err_hold_rdata", ReadData, 32'h123455EF);
    access(1, 0, 3'b010, 32'h10, 32'h0, 0, -1, 1, 32'h123455EF);

    // reset in the middle of a store
    access(0, 1, 3'b010, 32'h20, 32'hFFFFFFFF, 0, -1, 0, 32'h0);
    access(0, 1, 3'b010, 32'h20, 32'h11223344, 0, 2, 0, 32'h0);
    idle(1);
    access(1, 0, 3'b010, 32'h20, 32'h0, 0, -1, 1, 32'hFFFF3344);

    // request held through DONE, then back-to-back; address aliasing
    access(1, 0, 3'b010, 32'h10, 32'h0, 1, -1, 1, 32'h123455EF);
    access(1, 0, 3'b000, 32'h11, 32'h0, 0, -1, 1, 32'h00000055);
    access(0, 1, 3'b010, 32'h1010, 32'hCAFEF00D, 0, -1, 0, 32'h0);
    access(1, 0, 3'b010, 32'h010, 32'h0, 0, -1, 1, 32'hCAFEF00D);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
